// File: rtl/fetch_ctrl.sv
// Run controller for the instruction-fetch stage: sequences start, the PC reset
// window, run and halt, and resolves branch requests into a single-cycle branchsig.
module fetch_ctrl #(
  parameter int RESET_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_instr,
  input  logic             stall_req,
  input  logic             branch_req,
  input  logic             branch_type,
  input  logic [7:0]       cmp,
  output logic             if_reset,
  output logic             if_halt,
  output logic             branchsig,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count,
  output logic [7:0]       taken_count
);

  localparam int INIT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(RESET_CYCLES - 1);
  localparam logic [INIT_W-1:0] INIT_ONE  = INIT_W'(1);
  localparam logic [INIT_W-1:0] INIT_ZERO = {INIT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PC_INIT = 2'd1,
    RUN     = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              start_q;
  logic              start_rise;
  logic              taken;
  logic [INIT_W-1:0] init_cnt;

  assign start_rise = start & ~start_q;

  // Branch condition: equal-to-zero or negative, selected by branch_type.
  always_comb begin
    taken = 1'b0;
    if (branch_type) begin
      taken = (cmp == 8'h00);
    end else begin
      taken = cmp[7];
    end
  end

  // Next-state decode and IF control outputs.
  always_comb begin
    state_nxt = state;
    if_reset  = 1'b1;
    if_halt   = 1'b1;
    branchsig = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start_rise) state_nxt = PC_INIT;
        else            state_nxt = IDLE;
      end
      PC_INIT: begin
        if (init_cnt == INIT_ZERO) state_nxt = RUN;
        else                       state_nxt = PC_INIT;
      end
      RUN: begin
        if_reset  = 1'b0;
        if_halt   = stall_req | halt_instr;
        // A halt or stall in the same cycle suppresses the branch entirely.
        branchsig = branch_req & taken & ~stall_req & ~halt_instr;
        if (halt_instr) state_nxt = DONE;
        else            state_nxt = RUN;
      end
      DONE: begin
        if_reset = 1'b0;
        done     = 1'b1;
        if (start_rise) state_nxt = PC_INIT;
        else            state_nxt = DONE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register and start edge detector.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= start;
    end
  end

  // Init window counter and saturating run/branch counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      init_cnt    <= INIT_ZERO;
      cycle_count <= CNT_ZERO;
      taken_count <= 8'h00;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_rise) begin
            init_cnt    <= INIT_LOAD;
            cycle_count <= CNT_ZERO;
            taken_count <= 8'h00;
          end
        end
        PC_INIT: begin
          if (init_cnt != INIT_ZERO) init_cnt <= init_cnt - INIT_ONE;
        end
        RUN: begin
          if (cycle_count != CNT_MAX) cycle_count <= cycle_count + CNT_ONE;
          if (branchsig && (taken_count != 8'hFF)) taken_count <= taken_count + 8'h01;
        end
        default: begin
          init_cnt <= INIT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed vectors push hand-computed expectations,
// a negedge monitor pops and compares both a default and a CNT_W=4 instance.
module tb_fetch_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       halt_instr = 1'b0;
  logic       stall_req = 1'b0;
  logic       branch_req = 1'b0;
  logic       branch_type = 1'b0;
  logic [7:0] cmp = 8'h00;

  logic        if_reset, if_halt, branchsig, done;
  logic [15:0] cycle_count;
  logic [7:0]  taken_count;
  logic        if_reset4, if_halt4, branchsig4, done4;
  logic [3:0]  cycle_count4;
  logic [7:0]  taken_count4;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_instr(halt_instr),
    .stall_req(stall_req), .branch_req(branch_req), .branch_type(branch_type),
    .cmp(cmp), .if_reset(if_reset), .if_halt(if_halt), .branchsig(branchsig),
    .done(done), .cycle_count(cycle_count), .taken_count(taken_count)
  );

  fetch_ctrl #(.RESET_CYCLES(2), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .halt_instr(halt_instr),
    .stall_req(stall_req), .branch_req(branch_req), .branch_type(branch_type),
    .cmp(cmp), .if_reset(if_reset4), .if_halt(if_halt4), .branchsig(branchsig4),
    .done(done4), .cycle_count(cycle_count4), .taken_count(taken_count4)
  );

  typedef struct {
    string name;
    logic  ifr;
    logic  ifh;
    logic  bs;
    logic  dn;
    int    cc;
    int    cc4;
    int    tc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string vn, input string f, input logic [31:0] got, input logic [31:0] want);
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s.%s got=%0h exp=%0h", vn, f, got, want);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      n_vec++;
      chk(cur.name, "if_reset",     {31'd0, if_reset},      {31'd0, cur.ifr});
      chk(cur.name, "if_halt",      {31'd0, if_halt},       {31'd0, cur.ifh});
      chk(cur.name, "branchsig",    {31'd0, branchsig},     {31'd0, cur.bs});
      chk(cur.name, "done",         {31'd0, done},          {31'd0, cur.dn});
      chk(cur.name, "cycle_count",  {16'd0, cycle_count},   cur.cc);
      chk(cur.name, "taken_count",  {24'd0, taken_count},   cur.tc);
      chk(cur.name, "if_reset4",    {31'd0, if_reset4},     {31'd0, cur.ifr});
      chk(cur.name, "if_halt4",     {31'd0, if_halt4},      {31'd0, cur.ifh});
      chk(cur.name, "branchsig4",   {31'd0, branchsig4},    {31'd0, cur.bs});
      chk(cur.name, "done4",        {31'd0, done4},         {31'd0, cur.dn});
      chk(cur.name, "cycle_count4", {28'd0, cycle_count4},  cur.cc4);
      chk(cur.name, "taken_count4", {24'd0, taken_count4},  cur.tc);
    end
  end

  task automatic vec(input string nm, input logic rst, input logic st, input logic hi,
                     input logic stl, input logic br, input logic bt, input logic [7:0] c,
                     input logic e_ifr, input logic e_ifh, input logic e_bs, input logic e_dn,
                     input int e_cc, input int e_tc);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; start = st; halt_instr = hi; stall_req = stl;
    branch_req = br; branch_type = bt; cmp = c;
    e.name = nm; e.ifr = e_ifr; e.ifh = e_ifh; e.bs = e_bs; e.dn = e_dn;
    e.cc = e_cc; e.cc4 = (e_cc > 15) ? 15 : e_cc; e.tc = e_tc;
    exp_q.push_back(e);
  endtask

  initial begin
    //   name         rst st hi sl br bt cmp     ifr ifh bs dn cc tc
    vec("rst0",       1, 0, 0, 0, 0, 0, 8'h00,  1, 1, 0, 0, 0, 0);
    vec("idle1",      0, 0, 0, 0, 0, 0, 8'h00,  1, 1, 0, 0, 0, 0);
    vec("idle2",      0, 0, 0, 0, 1, 1, 8'h00,  1, 1, 0, 0, 0, 0);
    vec("start3",     0, 1, 0, 0, 0, 0, 8'h00,  1, 1, 0, 0, 0, 0);
    vec("init4",      0, 0, 0, 0, 0, 0, 8'h00,  1, 1, 0, 0, 0, 0);
    vec("init5",      0, 1, 0, 0, 0, 0, 8'h00,  1, 1, 0, 0, 0, 0);
    vec("run6",       0, 0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 0, 0, 0);
    vec("beq_00",     0, 0, 0, 0, 1, 1, 8'h00,  0, 0, 1, 0, 1, 0);
    vec("beq_01",     0, 0, 0, 0, 1, 1, 8'h01,  0, 0, 0, 0, 2, 1);
    vec("blt_ff",     0, 0, 0, 0, 1, 0, 8'hFF,  0, 0, 1, 0, 3, 1);
    vec("blt_7f",     0, 0, 0, 0, 1, 0, 8'h7F,  0, 0, 0, 0, 4, 2);
    vec("blt_stall",  0, 0, 0, 1, 1, 0, 8'hFF,  0, 1, 0, 0, 5, 2);
    vec("blt_unstl",  0, 0, 0, 0, 1, 0, 8'hFF,  0, 0, 1, 0, 6, 2);
    vec("halt_br",    0, 1, 1, 0, 1, 1, 8'h00,  0, 1, 0, 0, 7, 3);
    vec("done_hold1", 0, 1, 0, 0, 1, 1, 8'h00,  0, 1, 0, 1, 8, 3);
    vec("done_hold2", 0, 1, 0, 0, 0, 0, 8'h00,  0, 1, 0, 1, 8, 3);
    vec("done_low",   0, 0, 0, 0, 0, 0, 8'h00,  0, 1, 0, 1, 8, 3);
    vec("done_rise",  0, 1, 0, 0, 0, 0, 8'h00,  0, 1, 0, 1, 8, 3);
    vec("restart",    0, 0, 0, 0, 0, 0, 8'h00,  1, 1, 0, 0, 0, 0);
    vec("init_rst",   1, 0, 0, 0, 0, 0, 8'h00,  1, 1, 0, 0, 0, 0);
    vec("post_rst1",  0, 0, 0, 0, 0, 0, 8'h00,  1, 1, 0, 0, 0, 0);
    vec("start_b",    0, 1, 0, 0, 0, 0, 8'h00,  1, 1, 0, 0, 0, 0);
    vec("init_b1",    0, 0, 0, 0, 0, 0, 8'h00,  1, 1, 0, 0, 0, 0);
    vec("init_b2",    0, 0, 0, 0, 1, 1, 8'h00,  1, 1, 0, 0, 0, 0);
    vec("run_b0",     0, 0, 0, 0, 1, 1, 8'h00,  0, 0, 1, 0, 0, 0);
    vec("run_b1",     0, 1, 0, 0, 1, 0, 8'h80,  0, 0, 1, 0, 1, 1);
    vec("run_rst",    1, 0, 0, 0, 1, 1, 8'h00,  0, 0, 1, 0, 2, 2);
    vec("post_rst2",  0, 0, 0, 0, 0, 0, 8'h00,  1, 1, 0, 0, 0, 0);
    vec("start_c",    0, 1, 0, 0, 0, 0, 8'h00,  1, 1, 0, 0, 0, 0);
    vec("init_c1",    0, 1, 0, 0, 0, 0, 8'h00,  1, 1, 0, 0, 0, 0);
    vec("init_c2",    0, 1, 0, 0, 0, 0, 8'h00,  1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 22; k++) begin
      vec("sat_run",  0, 0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 0, k, 0);
    end
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time=%0t limit=100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
